// File: rtl/cpu_flags_pkg.sv
// Shared NZCV flag and condition-code types for the EX-stage flag logic and the
// ID-stage branch unit.
package cpu_flags_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    // Bit positions inside a {N,Z,C,V} nibble
    localparam logic [1:0] FLAG_N = 2'd3;
    localparam logic [1:0] FLAG_Z = 2'd2;
    localparam logic [1:0] FLAG_C = 2'd1;
    localparam logic [1:0] FLAG_V = 2'd0;

endpackage

// File: rtl/flag_register_stage_if.sv
// EX-stage flag/result bus. The slave side is the flag register stage; the master
// side is whatever drives the ALU outputs and the branch request.
interface flag_register_stage_if #(
    parameter int WIDTH = 64
) ();
    // Valid/ready: there is no backpressure here. ex_valid qualifies the EX slot,
    // stall freezes all state, flush squashes the EX slot; mem_valid qualifies mem_result.
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic             alu_overflow;
    logic             ex_valid;
    logic             set_flags;
    logic             stall;
    logic             flush;
    logic [3:0]       cond;
    logic             cond_req;
    logic [3:0]       flags_q;
    logic [3:0]       flags_fwd;
    logic             cond_taken;
    logic [WIDTH-1:0] mem_result;
    logic             mem_valid;

    modport master (
        output alu_result, alu_cout, alu_overflow, ex_valid, set_flags,
               stall, flush, cond, cond_req,
        input  flags_q, flags_fwd, cond_taken, mem_result, mem_valid
    );

    modport slave (
        input  alu_result, alu_cout, alu_overflow, ex_valid, set_flags,
               stall, flush, cond, cond_req,
        output flags_q, flags_fwd, cond_taken, mem_result, mem_valid
    );
endinterface

// File: rtl/cond_eval.sv
// Purely combinational ARM condition-code evaluator: condition + NZCV -> taken.
module cond_eval
    import cpu_flags_pkg::*;
(
    input  cond_e cond_i,
    input  nzcv_t flags_i,
    output logic  taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_EQ: taken_o = flags_i.z;
            COND_NE: taken_o = !flags_i.z;
            COND_CS: taken_o = flags_i.c;
            COND_CC: taken_o = !flags_i.c;
            COND_MI: taken_o = flags_i.n;
            COND_PL: taken_o = !flags_i.n;
            COND_VS: taken_o = flags_i.v;
            COND_VC: taken_o = !flags_i.v;
            COND_HI: taken_o = flags_i.c && !flags_i.z;
            COND_LS: taken_o = !(flags_i.c && !flags_i.z);
            COND_GE: taken_o = (flags_i.n == flags_i.v);
            COND_LT: taken_o = (flags_i.n != flags_i.v);
            COND_GT: taken_o = !flags_i.z && (flags_i.n == flags_i.v);
            COND_LE: taken_o = !(!flags_i.z && (flags_i.n == flags_i.v));
            COND_AL: taken_o = 1'b1;
            COND_NV: taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_register_stage.sv
// EX-stage NZCV flag register with same-cycle forwarding to B.cond, plus EX/MEM result register.
// Define FLAG_COND_REG_EN to register cond_taken (one cycle later, holds on stall, clears on flush).
module flag_register_stage
    import cpu_flags_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    flag_register_stage_if.slave bus
);

    logic [3:0]       new_vec;
    nzcv_t            new_flags;
    nzcv_t            fwd_flags;
    nzcv_t            flags_d;
    nzcv_t            flags_reg_q;
    logic             fwd_sel;
    logic             upd;
    logic [WIDTH-1:0] mem_result_d;
    logic [WIDTH-1:0] mem_result_q;
    logic             mem_valid_d;
    logic             mem_valid_q;
    logic             eval_taken;
    logic             cond_taken_d;

    always_comb begin
        new_vec         = 4'b0000;
        new_vec[FLAG_N] = bus.alu_result[WIDTH-1];
        new_vec[FLAG_Z] = (bus.alu_result == '0);
        new_vec[FLAG_C] = bus.alu_cout;
        new_vec[FLAG_V] = bus.alu_overflow;
        new_flags       = nzcv_t'(new_vec);
    end

    // Forwarding ignores stall: a stalled CMP still presents its flags to the B.cond behind it.
    assign fwd_sel   = bus.ex_valid & bus.set_flags & ~bus.flush;
    assign upd       = fwd_sel & ~bus.stall;
    assign fwd_flags = fwd_sel ? new_flags : flags_reg_q;

    always_comb begin
        flags_d      = flags_reg_q;
        mem_result_d = mem_result_q;
        mem_valid_d  = mem_valid_q;
        if (upd) begin
            flags_d = new_flags;
        end
        if (!bus.stall) begin
            if (bus.flush) begin
                mem_valid_d = 1'b0;
            end else begin
                mem_result_d = bus.alu_result;
                mem_valid_d  = bus.ex_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_reg_q  <= '0;
            mem_result_q <= '0;
            mem_valid_q  <= 1'b0;
        end else begin
            flags_reg_q  <= flags_d;
            mem_result_q <= mem_result_d;
            mem_valid_q  <= mem_valid_d;
        end
    end

    cond_eval u_cond_eval (
        .cond_i  (cond_e'(bus.cond)),
        .flags_i (fwd_flags),
        .taken_o (eval_taken)
    );

    assign cond_taken_d = bus.cond_req & eval_taken;

`ifdef FLAG_COND_REG_EN
    logic cond_taken_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cond_taken_q <= 1'b0;
        end else if (!bus.stall) begin
            cond_taken_q <= bus.flush ? 1'b0 : cond_taken_d;
        end
    end

    assign bus.cond_taken = cond_taken_q;
`else
    assign bus.cond_taken = cond_taken_d;
`endif

    assign bus.flags_q    = flags_reg_q;
    assign bus.flags_fwd  = fwd_flags;
    assign bus.mem_result = mem_result_q;
    assign bus.mem_valid  = mem_valid_q;

endmodule
